// File: rtl/ce_timer_scheduler.sv
// Shared-tick timeout scheduler: one prescaler, NUM_CH one-shot delay
// channels armed via round-robin request/grant; done pulses on expiry.
// Ports: iClk, iRst (async, active-high); ivReq/ivDelay/ivCancel per
// channel in; ovGnt (grant pulse), ovBusy (counting), ovDone (expiry
// pulse) per channel out; oTick shared tick pulse out.
// Optional: define CE_SCHED_FREEZE_EN to add iFreeze, which pauses the
// prescaler (oTick held low) while grants, loads and cancels continue.
module ce_timer_scheduler #(
  parameter int CLK_DIV = 12_500_000,
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8
) (
  input  logic                    iClk,
  input  logic                    iRst,
`ifdef CE_SCHED_FREEZE_EN
  input  logic                    iFreeze,
`endif
  input  logic [NUM_CH-1:0]       ivReq,
  input  logic [NUM_CH*CNT_W-1:0] ivDelay,
  input  logic [NUM_CH-1:0]       ivCancel,
  output logic [NUM_CH-1:0]       ovGnt,
  output logic [NUM_CH-1:0]       ovBusy,
  output logic [NUM_CH-1:0]       ovDone,
  output logic                    oTick
);

  localparam int PW =
    (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
  localparam int PTR_W = $clog2(NUM_CH);
  localparam logic [PW-1:0] DIV = PW'(CLK_DIV);

  logic [PW-1:0]    presc;
  logic             tickQ;
  logic             freeze;
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [NUM_CH-1:0] zeroPend;

  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] gntVec;
  logic [PTR_W-1:0]  gntIdx;
  logic [PTR_W-1:0]  nextPtr;
  logic              found;

`ifdef CE_SCHED_FREEZE_EN
  assign freeze = iFreeze;
`else
  assign freeze = 1'b0;
`endif

  assign oTick = tickQ & ~freeze;

  // A channel whose grant is showing this cycle is masked so a
  // zero-delay load cannot be re-granted while its done is pending.
  assign elig = ivReq & ~ovBusy & ~ivCancel & ~ovGnt;

  always_comb begin : arb
    int idx;
    idx    = 0;
    found  = 1'b0;
    gntIdx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (!found && elig[idx]) begin
        found  = 1'b1;
        gntIdx = PTR_W'(idx);
      end
    end
    gntVec = '0;
    if (found) gntVec[gntIdx] = 1'b1;
    if (int'(gntIdx) == NUM_CH - 1) nextPtr = '0;
    else nextPtr = gntIdx + 1'b1;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      presc    <= '0;
      tickQ    <= 1'b0;
      ptr      <= '0;
      ovGnt    <= '0;
      ovBusy   <= '0;
      ovDone   <= '0;
      zeroPend <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      if (freeze) begin
        tickQ <= 1'b0;
      end else if (presc == DIV) begin
        presc <= '0;
        tickQ <= 1'b1;
      end else begin
        presc <= presc + 1'b1;
        tickQ <= 1'b0;
      end

      ovGnt <= gntVec;
      if (found) ptr <= nextPtr;

      for (int i = 0; i < NUM_CH; i++) begin
        zeroPend[i] <= 1'b0;
        ovDone[i]   <= zeroPend[i];
        if (gntVec[i]) begin
          // Loaded channels skip a coincident tick.
          if (ivDelay[i*CNT_W +: CNT_W] != '0) begin
            cnt[i]    <= ivDelay[i*CNT_W +: CNT_W];
            ovBusy[i] <= 1'b1;
          end else begin
            zeroPend[i] <= 1'b1;
          end
        end else if (ovBusy[i]) begin
          if (ivCancel[i]) begin
            cnt[i]    <= '0;
            ovBusy[i] <= 1'b0;
          end else if (oTick) begin
            if (cnt[i] == CNT_W'(1)) begin
              cnt[i]    <= '0;
              ovBusy[i] <= 1'b0;
              ovDone[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] - 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
